// File: rtl/inst_seq.sv
// inst_seq: per-tile instruction sequencer for the conv core.
// Ports: clk, reset (async, active-low), start, ofifo_valid in; inst[33:0], busy, done, kij[3:0] out.
module inst_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 36,
    parameter int len_kij = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij
);

    typedef enum logic [3:0] {
        IDLE,
        WLOAD,
        KLOAD,
        KDRAIN,
        GAP,
        AL0,
        EXEC,
        OFRD,
        NEXT,
        DONE
    } state_t;

    localparam int N_WLOAD  = 2 * col;
    localparam int N_KLOAD  = row + col;
    localparam int N_KDRAIN = col;
    localparam int N_GAP    = 10;
    localparam int N_AL0    = 2 * len_nij;
    localparam int N_EXEC   = 2 * len_nij + row + col;
    localparam int N_OFRD   = len_nij;

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  kij_q, kij_d;
    logic [33:0] inst_d;
    logic        busy_d;
    logic        done_d;
    logic [10:0] xa_w;
    logic [10:0] pa_o;

    assign kij = kij_q;

    // Outputs are computed for the upcoming cycle and registered together
    // with the state, so inst always describes the phase the FSM is in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            inst    <= IDLE_WORD;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            inst    <= inst_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        kij_d   = kij_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = WLOAD;
            end
            WLOAD: begin
                if (cnt_q == 16'(N_WLOAD - 1)) state_d = KLOAD;
            end
            KLOAD: begin
                if (cnt_q == 16'(N_KLOAD - 1)) state_d = KDRAIN;
            end
            KDRAIN: begin
                if (cnt_q == 16'(N_KDRAIN - 1)) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == 16'(N_GAP - 1)) state_d = AL0;
            end
            AL0: begin
                if (cnt_q == 16'(N_AL0 - 1)) state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == 16'(N_EXEC - 1)) state_d = OFRD;
            end
            OFRD: begin
                // In OFRD cnt counts completed writes; a stall cycle
                // (no ofifo_rd issued) holds it so no address is skipped.
                if (!inst[6]) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == 16'(N_OFRD - 1)) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (kij_q < 4'(len_kij - 1)) begin
                    kij_d   = kij_q + 4'd1;
                    state_d = WLOAD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                kij_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q || state_d == IDLE) cnt_d = '0;
    end

    always_comb begin
        inst_d = IDLE_WORD;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        xa_w   = 11'(1024 + 2 * col * int'(kij_d) + int'(cnt_d));
        pa_o   = 11'(len_nij * int'(kij_d) + int'(cnt_d));
        unique case (state_d)
            WLOAD: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = xa_w;
                inst_d[5]    = 1'b1;
            end
            KLOAD: begin
                inst_d[4] = 1'b1;
                inst_d[0] = 1'b1;
            end
            KDRAIN: begin
                inst_d[0] = 1'b1;
            end
            AL0: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = 11'(cnt_d);
                inst_d[2]    = 1'b1;
            end
            EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            OFRD: begin
                if (ofifo_valid) begin
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = pa_o;
                    inst_d[6]     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_inst_seq.sv
// tb_inst_seq: checks inst_seq against a phase-walking reference model.
// Ports driven: clk, reset, start, ofifo_valid; all outputs compared every cycle.
module tb_inst_seq;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int NIJ  = 36;
    localparam int KIJ  = 9;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    int n_chk  = 0;
    int n_fail = 0;
    int exec_seen = 0;

    inst_seq #(.row(ROW), .col(COL), .len_nij(NIJ), .len_kij(KIJ)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ofifo_valid(ofifo_valid),
        .inst(inst),
        .busy(busy),
        .done(done),
        .kij(kij)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] w_wload(int k, int i);
        logic [33:0] w = IDLE_W;
        w[19]   = 1'b0;
        w[5]    = 1'b1;
        w[17:7] = 11'((1024 + 2 * COL * k + i) % 2048);
        return w;
    endfunction

    function automatic logic [33:0] w_al0(int i);
        logic [33:0] w = IDLE_W;
        w[19]   = 1'b0;
        w[2]    = 1'b1;
        w[17:7] = 11'(i);
        return w;
    endfunction

    function automatic logic [33:0] w_ofrd(int k, int i);
        logic [33:0] w = IDLE_W;
        w[32]    = 1'b0;
        w[31]    = 1'b0;
        w[6]     = 1'b1;
        w[30:20] = 11'((NIJ * k + i) % 2048);
        return w;
    endfunction

    function automatic logic [33:0] w_bits(int a, int b);
        logic [33:0] w = IDLE_W;
        w[a] = 1'b1;
        w[b] = 1'b1;
        return w;
    endfunction

    function automatic void check(string nm, logic [33:0] ei, logic eb,
                                  logic ed, logic [3:0] ek);
        n_chk++;
        if (inst !== ei || busy !== eb || done !== ed || kij !== ek) begin
            n_fail++;
            $display("FAIL %s t=%0t inst=%h exp=%h busy=%b exp=%b done=%b exp=%b kij=%0d exp=%0d",
                     nm, $time, inst, ei, busy, eb, done, ed, kij, ek);
        end
    endfunction

    function automatic void check_int(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endfunction

    // Apply inputs for the next edge, then compare the cycle that follows.
    task automatic cyc(input logic st, input logic ov, input logic [33:0] ei,
                       input logic eb, input logic ed, input int ek, input string nm);
        start       = st;
        ofifo_valid = ov;
        @(posedge clk);
        #1;
        if (inst[1]) exec_seen++;
        check(nm, ei, eb, ed, 4'(ek));
    endtask

    function automatic logic rnd_start(int mode);
        return (mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
    endfunction

    function automatic logic rnd_valid(int mode);
        return (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // mode 0: valid held high; 1: valid toggles 1,0 in OFRD;
    // 2: random valid and random start pulses while busy.
    task automatic run_tile(input int mode, input int abort_k,
                            output int cycles, output int ofrd0,
                            output int last_pa);
        int t = 0;
        cycles = -1;
        ofrd0 = 0;
        last_pa = -1;
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < 2 * COL; i++) begin
                cyc((k == 0 && i == 0) ? 1'b1 : rnd_start(mode), rnd_valid(mode),
                    w_wload(k, i), 1, 0, k, "wload");
                t++;
            end
            for (int i = 0; i < ROW + COL; i++) begin
                cyc(rnd_start(mode), rnd_valid(mode), w_bits(4, 0), 1, 0, k, "kload");
                t++;
            end
            for (int i = 0; i < COL; i++) begin
                cyc(rnd_start(mode), rnd_valid(mode), w_bits(0, 0), 1, 0, k, "kdrain");
                t++;
            end
            for (int i = 0; i < 10; i++) begin
                cyc(rnd_start(mode), rnd_valid(mode), IDLE_W, 1, 0, k, "gap");
                t++;
            end
            for (int i = 0; i < 2 * NIJ; i++) begin
                if (k == abort_k && i == 10) begin
                    start = 1'b0;
                    ofifo_valid = 1'b1;
                    #2;
                    reset = 1'b0;
                    #1;
                    check("abort_now", IDLE_W, 0, 0, 4'd0);
                    repeat (3) @(posedge clk);
                    #1;
                    check("abort_hold", IDLE_W, 0, 0, 4'd0);
                    reset = 1'b1;
                    return;
                end
                cyc(rnd_start(mode), rnd_valid(mode), w_al0(i), 1, 0, k, "al0");
                t++;
            end
            for (int i = 0; i < 2 * NIJ + ROW + COL; i++) begin
                cyc((mode == 0 && k == 2 && i == 40) ? 1'b1 : rnd_start(mode),
                    rnd_valid(mode), w_bits(3, 1), 1, 0, k, "exec");
                t++;
            end
            begin
                int w = 0;
                int len = 0;
                logic tog = 1'b1;
                logic v;
                while (w < NIJ) begin
                    if (mode == 1) v = tog;
                    else v = rnd_valid(mode);
                    tog = ~tog;
                    cyc(rnd_start(mode), v, v ? w_ofrd(k, w) : IDLE_W, 1, 0, k, "ofrd");
                    if (v) begin
                        last_pa = int'(inst[30:20]);
                        w++;
                    end
                    len++;
                    t++;
                end
                if (k == 0) ofrd0 = len;
            end
            cyc(rnd_start(mode), rnd_valid(mode), IDLE_W, 1, 0, k, "next");
            t++;
        end
        cyc(rnd_start(mode), rnd_valid(mode), IDLE_W, 1, 1, KIJ - 1, "done");
        cycles = t;
        cyc(1'b0, 1'b0, IDLE_W, 0, 0, 0, "back_idle");
    endtask

    initial begin
        int cyc_n;
        int ofrd0;
        int lpa;
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", IDLE_W, 0, 0, 4'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, IDLE_W, 0, 0, 0, "idle");

        exec_seen = 0;
        run_tile(0, -1, cyc_n, ofrd0, lpa);
        check_int("tile_cycles", cyc_n, 2223);
        check_int("last_apmem", lpa, 323);
        check_int("exec_cycles", exec_seen, 9 * 88);
        check_int("ofrd_len_solid", ofrd0, 36);

        run_tile(1, -1, cyc_n, ofrd0, lpa);
        check_int("ofrd_len_toggle", ofrd0, 71);
        check_int("tile_cycles_toggle", cyc_n, 2223 + 9 * 35);
        check_int("last_apmem_toggle", lpa, 323);

        run_tile(2, -1, cyc_n, ofrd0, lpa);
        check_int("last_apmem_rand", lpa, 323);

        run_tile(0, 4, cyc_n, ofrd0, lpa);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, IDLE_W, 0, 0, 0, "post_abort");

        run_tile(0, -1, cyc_n, ofrd0, lpa);
        check_int("tile_cycles_after_abort", cyc_n, 2223);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_seq.md
INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 SHALL have parameter row, default 8: PE array rows (input channels).
REQ-002 SHALL have parameter col, default 8: PE array columns (output channels).
REQ-003 SHALL have parameter len_nij, default 36: activation pixels per tile.
REQ-004 SHALL have parameter len_kij, default 9: kernel positions.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to run one full tile.
REQ-008 SHALL have port ofifo_valid, input, 1 bit: the core's OFIFO holds a complete output row.
REQ-009 SHALL have port inst, output, 34 bits: core instruction word, same bit map as the core inst bus.
- [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem.
- [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem.
- [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the sequencer is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the tile completes.
REQ-012 SHALL have port kij, output, 4 bits: current kernel position.

Function
REQ-013 SHALL register inst, busy, done and kij; no combinational path from any input to any output.
REQ-014 SHALL drive the idle word 34'h1_800C_0000 whenever no phase asserts a bit (CEN/WEN high, all else 0).
REQ-015 SHALL use an FSM with states IDLE, WLOAD, KLOAD, KDRAIN, GAP, AL0, EXEC, OFRD, NEXT, DONE, each phase timed by one shared cycle counter cnt.
REQ-016 SHALL leave IDLE on start=1; the first WLOAD word appears on inst on the edge after start is sampled.
REQ-017 SHALL ignore start while busy=1.
REQ-018 WLOAD SHALL last 2*col cycles with ififo_wr=1, CEN_xmem=0, WEN_xmem=1 and A_xmem=1024+2*col*kij+cnt.
REQ-019 KLOAD SHALL last row+col cycles with ififo_rd=1 and load=1.
REQ-020 KDRAIN SHALL last col cycles with load=1 and ififo_rd=0.
REQ-021 GAP SHALL last 10 cycles driving the idle word.
REQ-022 AL0 SHALL last 2*len_nij cycles with l0_wr=1, CEN_xmem=0, WEN_xmem=1 and A_xmem=cnt.
REQ-023 EXEC SHALL last 2*len_nij+row+col cycles with l0_rd=1 and execute=1.
REQ-024 OFRD SHALL issue len_nij writes, one per cycle in which ofifo_valid=1, each with ofifo_rd=1, CEN_pmem=0, WEN_pmem=0 and A_pmem=len_nij*kij+cnt.
REQ-025 In OFRD, when ofifo_valid=0 the block SHALL drive the idle word and hold cnt (stall, no address skip).
REQ-026 NEXT SHALL last one cycle: if kij<len_kij-1, increment kij and enter WLOAD; otherwise enter DONE.
REQ-027 DONE SHALL last one cycle with done=1 and busy=1, then enter IDLE with kij=0.
REQ-028 cnt SHALL clear to 0 on every state change, and A_xmem/A_pmem SHALL be truncated to 11 bits.
REQ-029 acc (inst[33]) SHALL be 0 in all states; accumulation is sequenced elsewhere.

Reset
REQ-030 reset=0 SHALL asynchronously force state=IDLE, cnt=0, kij=0, busy=0, done=0 and inst=34'h1_800C_0000.
REQ-031 Reset asserted mid-tile SHALL abort the tile with no done pulse; after release the block waits for a new start.

Verification
REQ-032 Reset then idle: inst=34'h1_800C_0000, busy=0, kij=0 for 5 cycles with start=0.
REQ-033 start pulse, ofifo_valid=1 held: kij=0 WLOAD shows A_xmem 1024..1039 on 16 consecutive cycles; EXEC is exactly 88 cycles; OFRD shows A_pmem 0..35.
REQ-034 Full tile, ofifo_valid=1: done pulses exactly 9*247=2223 cycles after the first WLOAD word; the last OFRD A_pmem is 323; kij then returns to 0.
REQ-035 ofifo_valid toggles 1,0 in OFRD: 36 writes still occur with A_pmem contiguous; the idle word appears on each stall cycle; OFRD spans 71 cycles.
REQ-036 start asserted again during EXEC: ignored; kij sequence and total cycle count unchanged.
REQ-037 reset=0 during kij=4 AL0: outputs return to reset values immediately; after a new start, WLOAD begins at A_xmem=1024.
